// File: rtl/square_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : square_conditioner
//  Purpose  : Conditions a raw asynchronous square wave into a clean,
//             debounced level with one-cycle edge pulses, a signal-loss
//             indicator and a saturating count of rejected glitches.
//  Ports    :
//    clk            in   1  single clock, rising edge
//    reset          in   1  synchronous, active-high reset
//    square         in   1  raw asynchronous square-wave input
//    square_clean   out  1  filtered, debounced level
//    fall_pulse     out  1  one-cycle pulse per accepted 1->0 transition
//    rise_pulse     out  1  one-cycle pulse per accepted 0->1 transition
//    signal_present out  1  high while accepted transitions keep arriving
//    glitch_count   out  8  saturating count of rejected excursions
//  Parameters (all must be >= 1):
//    FILTER_CYCLES  cycles a new level must persist before acceptance
//    HOLDOFF_CYCLES dead time after an accepted transition
//    SILENCE_CYCLES cycles without a transition before signal loss
//  Revision : 1.0  initial release
// ============================================================================
module square_conditioner #(
  parameter int FILTER_CYCLES  = 8,
  parameter int HOLDOFF_CYCLES = 4800,
  parameter int SILENCE_CYCLES = 4_800_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       square,
  output logic       square_clean,
  output logic       fall_pulse,
  output logic       rise_pulse,
  output logic       signal_present,
  output logic [7:0] glitch_count
);

  localparam int FILT_W = $clog2(FILTER_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES) + 1;
  localparam int SIL_W  = $clog2(SILENCE_CYCLES) + 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [SIL_W-1:0]  SIL_MAX   = SIL_W'(SILENCE_CYCLES);

  typedef enum logic [0:0] {
    ARMED   = 1'b0,
    HOLDOFF = 1'b1
  } state_t;

  state_t              state;
  logic                sync1;
  logic                sync2;
  logic [FILT_W-1:0]   filter_cnt;
  logic [HOLD_W-1:0]   holdoff_cnt;
  logic [SIL_W-1:0]    silence_cnt;
  logic [SIL_W-1:0]    silence_inc;
  logic                accept;

  // The qualifying edge: the new level has been seen for FILTER_CYCLES
  // consecutive armed cycles, counting the one at this edge.
  assign accept      = (state == ARMED) && (sync2 != square_clean) &&
                       (filter_cnt == FILT_LAST);
  assign silence_inc = silence_cnt + 1'b1;

  // Two-flop synchronizer; nothing downstream looks at the raw input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= square;
      sync2 <= sync1;
    end
  end

  // Debounce / holdoff state machine with registered level and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARMED;
      filter_cnt   <= '0;
      holdoff_cnt  <= '0;
      square_clean <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      glitch_count <= 8'd0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        ARMED: begin
          if (sync2 != square_clean) begin
            if (accept) begin
              square_clean <= sync2;
              rise_pulse   <= sync2;
              fall_pulse   <= ~sync2;
              filter_cnt   <= '0;
              holdoff_cnt  <= '0;
              state        <= HOLDOFF;
            end else begin
              filter_cnt <= filter_cnt + 1'b1;
            end
          end else begin
            // Input went back before qualifying: that was a glitch.
            if ((filter_cnt != '0) && (glitch_count != 8'hFF)) begin
              glitch_count <= glitch_count + 8'd1;
            end
            filter_cnt <= '0;
          end
        end
        HOLDOFF: begin
          // Level is frozen; a difference still present afterwards has to
          // re-qualify from zero once armed again.
          filter_cnt <= '0;
          if (holdoff_cnt == HOLD_LAST) begin
            holdoff_cnt <= '0;
            state       <= ARMED;
          end else begin
            holdoff_cnt <= holdoff_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ARMED;
          filter_cnt <= '0;
        end
      endcase
    end
  end

  // Silence timer: zero in every pulse cycle, saturates at SILENCE_CYCLES.
  // signal_present is registered from the counter's next value so it lines
  // up with the counter it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      silence_cnt    <= SIL_MAX;
      signal_present <= 1'b0;
    end else if (accept) begin
      silence_cnt    <= '0;
      signal_present <= 1'b1;
    end else if (silence_cnt != SIL_MAX) begin
      silence_cnt    <= silence_inc;
      signal_present <= (silence_inc != SIL_MAX);
    end else begin
      signal_present <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/square_conditioner.md
SQUARE_CONDITIONER -- requirements
Module: square_conditioner

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 8: consecutive cycles the synchronized input must hold a new level before that level is accepted.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 4800: cycles after an accepted transition during which further transitions are ignored (10 kHz maximum at 48 MHz).
REQ-003 SHALL have parameter SILENCE_CYCLES, default 4_800_000: cycles without an accepted transition before signal loss is declared (100 ms at 48 MHz).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port square, input, 1 bit: raw asynchronous square-wave input.
REQ-007 SHALL have port square_clean, output, 1 bit: filtered, debounced level.
REQ-008 SHALL have port fall_pulse, output, 1 bit: one-cycle pulse per accepted falling transition; this feeds the downstream edge counter.
REQ-009 SHALL have port rise_pulse, output, 1 bit: one-cycle pulse per accepted rising transition.
REQ-010 SHALL have port signal_present, output, 1 bit: high while accepted transitions arrive within SILENCE_CYCLES of each other.
REQ-011 SHALL have port glitch_count, output, 8 bits: saturating count of rejected input excursions.

Function
REQ-012 SHALL pass square through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-013 SHALL hold FSM state ARMED or HOLDOFF.
REQ-014 In ARMED, the filter counter SHALL increment each cycle sync2 != square_clean and SHALL clear to 0 each cycle sync2 == square_clean.
REQ-015 When the counter holds FILTER_CYCLES-1 and sync2 != square_clean, at that edge square_clean SHALL take sync2, the counter SHALL clear, and the FSM SHALL go to HOLDOFF.
REQ-016 The pulse for a 1->0 accepted transition SHALL be fall_pulse=1; for 0->1 it SHALL be rise_pulse=1. The pulse SHALL be high exactly in the first cycle square_clean shows the new level, and never both pulses at once.
REQ-017 Latency: square_clean and the pulse SHALL update on the (FILTER_CYCLES+2)th rising clk edge, counting the first edge that samples the new raw level into sync1.
REQ-018 Glitch rejection: when the counter is nonzero and sync2 returns to square_clean, in ARMED, glitch_count SHALL increment by 1, saturating at 255 with no wrap.
REQ-019 In HOLDOFF, a holdoff counter SHALL count HOLDOFF_CYCLES cycles, then the FSM SHALL return to ARMED.
  - the filter counter SHALL be held at 0
  - square_clean SHALL be frozen
  - no pulse SHALL be emitted
  - glitch_count SHALL not change
REQ-020 A level difference that persists past HOLDOFF SHALL be re-qualified from counter 0 in ARMED (a full FILTER_CYCLES), not accepted immediately.
REQ-021 The silence counter SHALL clear to 0 on any pulse cycle, and otherwise increment, saturating at SILENCE_CYCLES.
REQ-022 signal_present SHALL be 1 when the silence counter < SILENCE_CYCLES, and 0 otherwise.
REQ-023 Parameter legality: FILTER_CYCLES >= 1, HOLDOFF_CYCLES >= 1, SILENCE_CYCLES >= 1; counter widths SHALL be sized by $clog2 of the respective parameter plus 1.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 While reset=1 at a clk edge, the following SHALL take these values:
  - sync1, sync2: 0
  - square_clean: 0
  - fall_pulse, rise_pulse: 0
  - filter and holdoff counters: 0
  - FSM: ARMED
  - glitch_count: 0
  - silence counter: SILENCE_CYCLES (saturated)
  - signal_present: 0
REQ-026 Reset asserted mid-HOLDOFF or mid-qualification SHALL abort the operation with no pulse; the first cycle after reset deasserts SHALL behave as ARMED with counter 0.
REQ-027 With square held high through reset release, a rising acceptance SHALL follow per REQ-017 (rise_pulse, no fall_pulse).

Verification (bench params FILTER_CYCLES=4, HOLDOFF_CYCLES=16, SILENCE_CYCLES=100)
REQ-028 Reset release with square=0 held for 200 cycles -> no pulses, square_clean=0, signal_present=0, glitch_count=0.
REQ-029 square 0->1, held -> rise_pulse is one cycle on the 6th edge after sampling; square_clean=1 in the same cycle; signal_present=1.
REQ-030 From clean=1: square low for 3 cycles then high, repeated 5 times -> no fall_pulse, glitch_count=5; glitch_count=255 persists after 300 such glitches.
REQ-031 From clean=1, square falls and rises again 8 cycles after fall_pulse, held high -> rise is frozen until HOLDOFF ends, then rise_pulse arrives 4 cycles after ARMED resumes.
REQ-032 Accepted edge followed by 100 idle cycles -> signal_present drops to 0 on exactly the 100th cycle after the pulse, and returns to 1 on the next pulse.
REQ-033 Reset asserted for 1 cycle during HOLDOFF and during a 3-cycle qualification -> no pulse; all outputs match REQ-025; normal qualification resumes afterwards.
